// File: rtl/snake_body_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snake_body_ctrl
//  Description : Snake body segment store and move sequencer. Latches the
//                requested heading, checks a step against the walls and the
//                body one segment per cycle, then shifts the body in one
//                cycle and reports the vacated tail cell for erasing.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_body_ctrl #(
  parameter int MAXLEN  = 8,
  parameter int INITLEN = 4,
  parameter int XDIM    = 10,
  parameter int YDIM    = 10,
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120,
  parameter int X0      = 80,
  parameter int Y0      = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dir_in,
  input  logic       dir_valid,
  input  logic       step,
  input  logic       grow,
  input  logic [2:0] rd_idx,
  output logic [7:0] rd_x,
  output logic [6:0] rd_y,
  output logic [3:0] length,
  output logic [7:0] tail_x,
  output logic [6:0] tail_y,
  output logic       tail_valid,
  output logic       busy,
  output logic       done,
  output logic       dead
);

  localparam int         c_IW      = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam logic [7:0] c_XD      = 8'(XDIM);
  localparam logic [6:0] c_YD      = 7'(YDIM);
  localparam logic [7:0] c_XMAX    = 8'(XSCREEN - XDIM);
  localparam logic [6:0] c_YMAX    = 7'(YSCREEN - YDIM);
  localparam logic [3:0] c_MAXLEN  = 4'(MAXLEN);
  localparam logic [3:0] c_INITLEN = 4'(INITLEN);
  localparam logic [1:0] c_RIGHT   = 2'b00;
  localparam logic [1:0] c_DOWN    = 2'b01;
  localparam logic [1:0] c_UP      = 2'b10;
  localparam logic [1:0] c_LEFT    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_DEAD  = 3'd4
  } state_t;

  state_t            r_state;
  logic [7:0]        r_seg_x [MAXLEN];
  logic [6:0]        r_seg_y [MAXLEN];
  logic [3:0]        r_len;
  logic [1:0]        r_dir_lat;
  logic [1:0]        r_dir_cmt;
  logic [1:0]        r_mv_dir;
  logic              r_grow_q;
  logic [7:0]        r_new_x;
  logic [6:0]        r_new_y;
  logic [c_IW-1:0]   r_chk_idx;
  logic [c_IW-1:0]   r_chk_last;
  logic [7:0]        r_tail_x;
  logic [6:0]        r_tail_y;
  logic              r_tail_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_dead;

  logic [7:0]        w_head_x;
  logic [6:0]        w_head_y;
  logic              w_wall;
  logic              w_grow_eff;
  logic [3:0]        w_chk_cnt;
  logic              w_hit;
  logic [c_IW-1:0]   w_tail_idx;

  // Candidate head and wall test for the currently latched heading
  always_comb begin
    w_head_x = r_seg_x[0];
    w_head_y = r_seg_y[0];
    w_wall   = 1'b0;
    case (r_dir_lat)
      c_RIGHT: begin
        w_head_x = r_seg_x[0] + c_XD;
        w_wall   = (r_seg_x[0] == c_XMAX);
      end
      c_DOWN: begin
        w_head_y = r_seg_y[0] + c_YD;
        w_wall   = (r_seg_y[0] == c_YMAX);
      end
      c_UP: begin
        w_head_y = r_seg_y[0] - c_YD;
        w_wall   = (r_seg_y[0] == 7'd0);
      end
      default: begin
        w_head_x = r_seg_x[0] - c_XD;
        w_wall   = (r_seg_x[0] == 8'd0);
      end
    endcase
  end

  // A full-length snake cannot grow, so growth is dropped at capture time;
  // the compare window then also covers only the segments that survive.
  assign w_grow_eff = grow && (r_len < c_MAXLEN);
  assign w_chk_cnt  = w_grow_eff ? r_len : (r_len - 4'd1);
  assign w_hit      = (r_new_x == r_seg_x[r_chk_idx]) && (r_new_y == r_seg_y[r_chk_idx]);
  assign w_tail_idx = c_IW'(r_len - 4'd1);

  // Heading latch: accepts any request that is not a reversal of the last move
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir_lat <= c_UP;
    end else if (dir_valid && ((dir_in ^ 2'b11) != r_dir_cmt)) begin
      r_dir_lat <= dir_in;
    end
  end

  // Move sequencer with segment store and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_len        <= c_INITLEN;
      r_dir_cmt    <= c_UP;
      r_mv_dir     <= c_UP;
      r_grow_q     <= 1'b0;
      r_new_x      <= 8'd0;
      r_new_y      <= 7'd0;
      r_chk_idx    <= '0;
      r_chk_last   <= '0;
      r_tail_x     <= 8'd0;
      r_tail_y     <= 7'd0;
      r_tail_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dead       <= 1'b0;
      for (int i = 0; i < MAXLEN; i++) begin
        if (i < INITLEN) begin
          r_seg_x[i] <= 8'(X0);
          r_seg_y[i] <= 7'(Y0 + i * YDIM);
        end else begin
          r_seg_x[i] <= 8'd0;
          r_seg_y[i] <= 7'd0;
        end
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (step) begin
            r_grow_q  <= w_grow_eff;
            r_mv_dir  <= r_dir_lat;
            r_new_x   <= w_head_x;
            r_new_y   <= w_head_y;
            r_chk_idx <= '0;
            r_chk_last <= c_IW'(w_chk_cnt - 4'd1);
            if (w_wall) begin
              r_state <= S_DEAD;
              r_dead  <= 1'b1;
            end else if (w_chk_cnt == 4'd0) begin
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_CHECK;
              r_busy  <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (w_hit) begin
            r_state <= S_DEAD;
            r_busy  <= 1'b0;
            r_dead  <= 1'b1;
          end else if (r_chk_idx == r_chk_last) begin
            r_state <= S_SHIFT;
          end else begin
            r_chk_idx <= r_chk_idx + 1'b1;
          end
        end
        S_SHIFT: begin
          for (int i = 1; i < MAXLEN; i++) begin
            r_seg_x[i] <= r_seg_x[i-1];
            r_seg_y[i] <= r_seg_y[i-1];
          end
          r_seg_x[0] <= r_new_x;
          r_seg_y[0] <= r_new_y;
          if (r_grow_q) begin
            r_tail_valid <= 1'b0;
            r_len        <= r_len + 4'd1;
          end else begin
            r_tail_x     <= r_seg_x[w_tail_idx];
            r_tail_y     <= r_seg_y[w_tail_idx];
            r_tail_valid <= 1'b1;
          end
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_dir_cmt <= r_mv_dir;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_DEAD;
          r_busy  <= 1'b0;
          r_dead  <= 1'b1;
        end
      endcase
    end
  end

  // Segment read port; indices past the live body read as zero
  always_comb begin
    rd_x = 8'd0;
    rd_y = 7'd0;
    if ({1'b0, rd_idx} < r_len) begin
      rd_x = r_seg_x[rd_idx[c_IW-1:0]];
      rd_y = r_seg_y[rd_idx[c_IW-1:0]];
    end
  end

  assign length     = r_len;
  assign tail_x     = r_tail_x;
  assign tail_y     = r_tail_y;
  assign tail_valid = r_tail_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dead       = r_dead;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_body_ctrl
//  Description : Self-checking bench for snake_body_ctrl: directed move table,
//                hand-written corner sequences and a randomized run against a
//                queue-based model of the snake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_body_ctrl;

  localparam int c_XS = 160;
  localparam int c_YS = 120;
  localparam int c_XD = 10;
  localparam int c_YD = 10;
  localparam int c_MAXLEN = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dir_in = 2'b00;
  logic       dir_valid = 1'b0;
  logic       step = 1'b0;
  logic       grow = 1'b0;
  logic [2:0] rd_idx = 3'd0;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic [3:0] length;
  logic [7:0] tail_x;
  logic [6:0] tail_y;
  logic       tail_valid;
  logic       busy;
  logic       done;
  logic       dead;

  int vectors = 0;
  int miscompares = 0;

  snake_body_ctrl dut (
    .clk(clk), .rst(rst), .dir_in(dir_in), .dir_valid(dir_valid), .step(step),
    .grow(grow), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .length(length),
    .tail_x(tail_x), .tail_y(tail_y), .tail_valid(tail_valid), .busy(busy),
    .done(done), .dead(dead)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       dv;
    bit [1:0] dir;
    bit       g;
    int       hx, hy, len, tv, tx, ty, dd, lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; step = 1'b0; grow = 1'b0; dir_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_dir(input bit [1:0] d);
    @(negedge clk);
    dir_valid = 1'b1; dir_in = d;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  task automatic rd(input int i, output int x, output int y);
    rd_idx = 3'(i);
    #1;
    x = int'(rd_x);
    y = int'(rd_y);
  endtask

  // Issues one step; lat counts edges from the sampling edge to done/dead
  task automatic do_step(input bit g, output int lat, output bit dn, output bit dd);
    @(negedge clk);
    step = 1'b1; grow = g;
    lat = -1; dn = 1'b0; dd = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin step = 1'b0; grow = 1'b0; end
      if (done) begin dn = 1'b1; lat = n; break; end
      if (dead) begin dd = 1'b1; lat = n; break; end
    end
    if (dn) begin
      @(posedge clk); #1;
      chk("done_pulse_width", int'(done), 0);
    end
  endtask

  task automatic chk_seg(input string name, input int i, input int ex, input int ey);
    int x, y;
    rd(i, x, y);
    chk({name, "_x"}, x, ex);
    chk({name, "_y"}, y, ey);
  endtask

  // Reference snake: queue of cells, head at index 0
  int  qx[$], qy[$];
  int  m_lat_dir, m_cmt_dir;
  int  m_tx, m_ty, m_tv;

  function automatic void model_reset();
    qx = {}; qy = {};
    for (int i = 0; i < 4; i++) begin
      qx.push_back(80);
      qy.push_back(30 + i * c_YD);
    end
    m_lat_dir = 2; m_cmt_dir = 2;
    m_tx = 0; m_ty = 0; m_tv = 0;
  endfunction

  function automatic void model_dir(input int d);
    if (d != 3 - m_cmt_dir) m_lat_dir = d;
  endfunction

  // Returns 1 if the move kills the snake; lat is the expected edge count
  function automatic bit model_move(input bit g, output int lat);
    int  d, hx, hy, nx, ny, n, hit;
    bit  ge;
    d = m_lat_dir; hx = qx[0]; hy = qy[0];
    if ((d == 0 && hx == c_XS - c_XD) || (d == 3 && hx == 0) ||
        (d == 2 && hy == 0) || (d == 1 && hy == c_YS - c_YD)) begin
      lat = 1;
      return 1'b1;
    end
    nx = hx + ((d == 0) ? c_XD : (d == 3) ? -c_XD : 0);
    ny = hy + ((d == 1) ? c_YD : (d == 2) ? -c_YD : 0);
    ge = g && (qx.size() < c_MAXLEN);
    n  = ge ? qx.size() : qx.size() - 1;
    hit = -1;
    for (int k = 0; k < n; k++)
      if (hit < 0 && qx[k] == nx && qy[k] == ny) hit = k;
    if (hit >= 0) begin
      lat = hit + 2;
      return 1'b1;
    end
    lat = n + 2;
    qx.push_front(nx); qy.push_front(ny);
    if (ge) m_tv = 0;
    else begin
      m_tx = qx.pop_back(); m_ty = qy.pop_back(); m_tv = 1;
    end
    m_cmt_dir = d;
    return 1'b0;
  endfunction

  vec_t tbl[6];

  initial begin
    int  lat, x, y, exp_lat, seed_moves;
    bit  dn, dd, exp_dead, g;
    bit [1:0] d;

    tbl[0] = '{dv:0, dir:2'b00, g:0, hx:80,  hy:20, len:4, tv:1, tx:80, ty:60, dd:0, lat:5};
    tbl[1] = '{dv:1, dir:2'b01, g:0, hx:80,  hy:10, len:4, tv:1, tx:80, ty:50, dd:0, lat:5};
    tbl[2] = '{dv:1, dir:2'b00, g:1, hx:90,  hy:10, len:5, tv:0, tx:80, ty:50, dd:0, lat:6};
    tbl[3] = '{dv:1, dir:2'b11, g:0, hx:100, hy:10, len:5, tv:1, tx:80, ty:40, dd:0, lat:6};
    tbl[4] = '{dv:1, dir:2'b10, g:0, hx:100, hy:0,  len:5, tv:1, tx:80, ty:30, dd:0, lat:6};
    tbl[5] = '{dv:0, dir:2'b00, g:0, hx:100, hy:0,  len:5, tv:1, tx:80, ty:30, dd:1, lat:1};

    // Reset state
    do_reset();
    #1;
    chk("rst_length", int'(length), 4);
    chk("rst_tail_valid", int'(tail_valid), 0);
    chk("rst_tail_x", int'(tail_x), 0);
    chk("rst_tail_y", int'(tail_y), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dead", int'(dead), 0);
    for (int i = 0; i < 4; i++) chk_seg("rst_seg", i, 80, 30 + 10 * i);
    chk_seg("rst_seg_beyond", 5, 0, 0);

    // Directed move table
    for (int v = 0; v < 6; v++) begin
      if (tbl[v].dv) set_dir(tbl[v].dir);
      do_step(tbl[v].g, lat, dn, dd);
      chk($sformatf("tbl%0d_dead", v), int'(dd), tbl[v].dd);
      chk($sformatf("tbl%0d_done", v), int'(dn), 1 - tbl[v].dd);
      chk($sformatf("tbl%0d_latency", v), lat, tbl[v].lat);
      chk_seg($sformatf("tbl%0d_head", v), 0, tbl[v].hx, tbl[v].hy);
      chk($sformatf("tbl%0d_length", v), int'(length), tbl[v].len);
      chk($sformatf("tbl%0d_tail_valid", v), int'(tail_valid), tbl[v].tv);
      chk($sformatf("tbl%0d_tail_x", v), int'(tail_x), tbl[v].tx);
      chk($sformatf("tbl%0d_tail_y", v), int'(tail_y), tbl[v].ty);
    end
    // Dead is absorbing: further steps do nothing
    do_step(1'b0, lat, dn, dd);
    chk("dead_step_no_done", int'(dn), 0);
    chk("dead_still", int'(dead), 1);
    chk("dead_busy", int'(busy), 0);
    chk_seg("dead_seg1", 1, 100, 10);

    // Right + grow from reset: head (90,30), seg4 (80,60)
    do_reset();
    set_dir(2'b00);
    do_step(1'b1, lat, dn, dd);
    chk("grow_done", int'(dn), 1);
    chk_seg("grow_head", 0, 90, 30);
    chk_seg("grow_seg4", 4, 80, 60);
    chk("grow_length", int'(length), 5);
    chk("grow_tail_valid", int'(tail_valid), 0);

    // Self collision: right, down, left, up
    do_step(1'b0, lat, dn, dd);
    set_dir(2'b01); do_step(1'b0, lat, dn, dd);
    set_dir(2'b11); do_step(1'b0, lat, dn, dd);
    chk("coil_pre_done", int'(dn), 1);
    set_dir(2'b10); do_step(1'b0, lat, dn, dd);
    chk("coil_dead", int'(dd), 1);
    chk("coil_no_done", int'(dn), 0);
    chk("coil_latency", lat, 5);
    chk_seg("coil_seg0", 0, 90, 40);
    chk_seg("coil_seg1", 1, 100, 40);
    chk_seg("coil_seg2", 2, 100, 30);
    chk_seg("coil_seg3", 3, 90, 30);
    chk_seg("coil_seg4", 4, 80, 30);

    // Reset in the middle of a move
    do_reset();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk);
    chk("midrst_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_length", int'(length), 4);
    chk_seg("midrst_head", 0, 80, 30);
    @(negedge clk); rst = 1'b0;
    do_step(1'b0, lat, dn, dd);
    chk("midrst_latency", lat, 5);
    chk_seg("midrst_step_head", 0, 80, 20);
    chk_seg("midrst_step_seg3", 3, 80, 50);
    chk("midrst_tail_y", int'(tail_y), 60);

    // Randomized moves against the reference snake
    do_reset();
    model_reset();
    seed_moves = 150;
    for (int m = 0; m < seed_moves; m++) begin
      if ($urandom_range(2) == 0) begin
        d = 2'($urandom_range(3));
        set_dir(d);
        model_dir(int'(d));
      end
      g = ($urandom_range(3) == 0);
      exp_dead = model_move(g, exp_lat);
      do_step(g, lat, dn, dd);
      chk("rnd_dead", int'(dd), int'(exp_dead));
      chk("rnd_latency", lat, exp_lat);
      if (exp_dead) begin
        do_reset();
        model_reset();
      end else begin
        chk("rnd_length", int'(length), qx.size());
        for (int i = 0; i < qx.size(); i++) begin
          rd(i, x, y);
          chk("rnd_seg_x", x, qx[i]);
          chk("rnd_seg_y", y, qy[i]);
        end
        if (qx.size() < 8) chk_seg("rnd_seg_beyond", qx.size(), 0, 0);
        chk("rnd_tail_valid", int'(tail_valid), m_tv);
        if (m_tv == 1) begin
          chk("rnd_tail_x", int'(tail_x), m_tx);
          chk("rnd_tail_y", int'(tail_y), m_ty);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
